// File: rtl/core_pkg.sv
// +----------------------------------------------------------------------+
// | core_pkg : opcode/funct3 constants, immediate formats, decode states |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package core_pkg;

    localparam logic [6:0] OP_LUI         = 7'b0110111;
    localparam logic [6:0] OP_AUIPC       = 7'b0010111;
    localparam logic [6:0] OP_JAL         = 7'b1101111;
    localparam logic [6:0] OP_JALR        = 7'b1100111;
    localparam logic [6:0] OP_BRANCH      = 7'b1100011;
    localparam logic [6:0] OP_LOAD        = 7'b0000011;
    localparam logic [6:0] OP_STORE       = 7'b0100011;
    localparam logic [6:0] OP_INTEGER_IMM = 7'b0010011;
    localparam logic [6:0] OP_INTEGER     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    function automatic imm_fmt_t imm_fmt(input logic [6:0] op);
        case (op)
            OP_JALR, OP_LOAD, OP_INTEGER_IMM: return IMM_I;
            OP_STORE:                         return IMM_S;
            OP_BRANCH:                        return IMM_B;
            OP_LUI, OP_AUIPC:                 return IMM_U;
            OP_JAL:                           return IMM_J;
            default:                          return IMM_NONE;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_LOAD, OP_INTEGER_IMM, OP_INTEGER: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_INTEGER_IMM, OP_INTEGER: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_if.sv
// +----------------------------------------------------------------------+
// | decode_if : fetch, register-file and execute signals of decode stage |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

interface decode_if #(
    parameter int M_WIDTH  = 32,
    parameter int OP_WIDTH = 7
);
    logic                instr_valid;
    logic [31:0]         instr;
    logic [M_WIDTH-1:0]  pc_in;
    logic                instr_ready;
    logic [4:0]          rf_rs1_addr;
    logic [4:0]          rf_rs2_addr;
    logic [M_WIDTH-1:0]  rf_rs1_data;
    logic [M_WIDTH-1:0]  rf_rs2_data;
    logic                ex_en;
    logic [OP_WIDTH-1:0] ex_op;
    logic [6:0]          ex_funct7;
    logic [2:0]          ex_funct3;
    logic [M_WIDTH-1:0]  ex_pc;
    logic [M_WIDTH-1:0]  ex_rs1;
    logic [M_WIDTH-1:0]  ex_rs2;
    logic [M_WIDTH-1:0]  ex_imm;
    logic [4:0]          ex_rd;
    logic                ex_wb_en;
    logic                ex_ready;
    logic                ex_flush;
    logic                wb_valid;
    logic                illegal_instr;

    // Decode stage view: it masters the issue bus towards execute.
    modport master (
        input  instr_valid, instr, pc_in, rf_rs1_data, rf_rs2_data, ex_ready, ex_flush,
        output instr_ready, rf_rs1_addr, rf_rs2_addr, ex_en, ex_op, ex_funct7, ex_funct3,
               ex_pc, ex_rs1, ex_rs2, ex_imm, ex_rd, ex_wb_en, wb_valid, illegal_instr
    );

    modport slave (
        output instr_valid, instr, pc_in, rf_rs1_data, rf_rs2_data, ex_ready, ex_flush,
        input  instr_ready, rf_rs1_addr, rf_rs2_addr, ex_en, ex_op, ex_funct7, ex_funct3,
               ex_pc, ex_rs1, ex_rs2, ex_imm, ex_rd, ex_wb_en, wb_valid, illegal_instr
    );

endinterface

`default_nettype wire

// File: rtl/decode_imm_gen.sv
// +----------------------------------------------------------------------+
// | imm_gen : builds the sign-extended immediate for a given format      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module imm_gen
    import core_pkg::*;
#(
    parameter int M_WIDTH = 32
) (
    input  wire logic [31:7]        instr,
    input  imm_fmt_t                fmt,
    output logic [M_WIDTH-1:0]      imm
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = '0;
        case (fmt)
            IMM_I:   w_imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   w_imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {instr[31:12], 12'b0};
            IMM_J:   w_imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign imm = M_WIDTH'($signed(w_imm32));

endmodule

`default_nettype wire

// File: rtl/decode.sv
// +----------------------------------------------------------------------+
// | decode : one-slot instruction buffer, field split and issue to EX.   |
// | Option : DECODE_ILLEGAL_TRAP_EN blocks unknown opcodes (sticky flag) |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module decode
    import core_pkg::*;
#(
    parameter int M_WIDTH  = 32,
    parameter int OP_WIDTH = 7
) (
    input  wire logic clk,
    input  wire logic rst_n,
    decode_if.master  bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_buf_full;
    logic [31:0]         r_buf_instr;
    logic [M_WIDTH-1:0]  r_buf_pc;
    logic                w_ex_en;
    logic                w_flush;
    logic                w_instr_ready;
    logic                w_accept;
    logic                w_transfer;
    logic                w_trap;
    imm_fmt_t            w_fmt;
    logic [M_WIDTH-1:0]  w_imm;

    logic [OP_WIDTH-1:0] r_ex_op;
    logic [6:0]          r_ex_funct7;
    logic [2:0]          r_ex_funct3;
    logic [M_WIDTH-1:0]  r_ex_pc;
    logic [M_WIDTH-1:0]  r_ex_rs1;
    logic [M_WIDTH-1:0]  r_ex_rs2;
    logic [M_WIDTH-1:0]  r_ex_imm;
    logic [4:0]          r_ex_rd;
    logic                r_ex_wb_en;

    assign w_ex_en       = (r_state == ST_ISSUE);
    assign w_flush       = w_ex_en && bus.ex_ready && bus.ex_flush;
    assign w_instr_ready = !r_buf_full && !w_flush;
    assign w_accept      = bus.instr_valid && w_instr_ready;
    assign w_fmt         = imm_fmt(r_buf_instr[6:0]);

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic w_trap_hit;
    logic r_illegal;

    assign w_trap     = !is_legal_op(r_buf_instr[6:0]);
    assign w_trap_hit = (r_state != ST_ISSUE) && r_buf_full && w_trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (w_trap_hit) begin
            r_illegal <= 1'b1;
        end
    end

    assign bus.illegal_instr = r_illegal;
`else
    assign w_trap            = 1'b0;
    assign bus.illegal_instr = 1'b0;
`endif

    imm_gen #(.M_WIDTH(M_WIDTH)) u_imm_gen (
        .instr (r_buf_instr[31:7]),
        .fmt   (w_fmt),
        .imm   (w_imm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RECOVER keeps ex_en low for one cycle before the next transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_transfer  = 1'b0;
        case (r_state)
            ST_IDLE, ST_RECOVER: begin
                if (r_state == ST_RECOVER) begin
                    w_state_nxt = ST_IDLE;
                end
                if (r_buf_full && !w_trap) begin
                    w_transfer  = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.ex_ready) begin
                    w_state_nxt = ST_RECOVER;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_full  <= 1'b0;
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
        end else begin
            if (w_flush || w_transfer) begin
                r_buf_full <= 1'b0;
            end else if (w_accept) begin
                r_buf_full <= 1'b1;
            end
            if (w_accept) begin
                r_buf_instr <= bus.instr;
                r_buf_pc    <= bus.pc_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_op     <= '0;
            r_ex_funct7 <= '0;
            r_ex_funct3 <= '0;
            r_ex_pc     <= '0;
            r_ex_rs1    <= '0;
            r_ex_rs2    <= '0;
            r_ex_imm    <= '0;
            r_ex_rd     <= '0;
            r_ex_wb_en  <= 1'b0;
        end else if (w_transfer) begin
            r_ex_op     <= r_buf_instr[OP_WIDTH-1:0];
            r_ex_funct7 <= r_buf_instr[31:25];
            r_ex_funct3 <= r_buf_instr[14:12];
            r_ex_pc     <= r_buf_pc;
            r_ex_rs1    <= bus.rf_rs1_data;
            r_ex_rs2    <= bus.rf_rs2_data;
            r_ex_imm    <= w_imm;
            r_ex_rd     <= r_buf_instr[11:7];
            r_ex_wb_en  <= writes_rd(r_buf_instr[6:0]) && (r_buf_instr[11:7] != 5'd0);
        end
    end

    assign bus.instr_ready = w_instr_ready;
    assign bus.rf_rs1_addr = r_buf_instr[19:15];
    assign bus.rf_rs2_addr = r_buf_instr[24:20];
    assign bus.ex_en       = w_ex_en;
    assign bus.ex_op       = r_ex_op;
    assign bus.ex_funct7   = r_ex_funct7;
    assign bus.ex_funct3   = r_ex_funct3;
    assign bus.ex_pc       = r_ex_pc;
    assign bus.ex_rs1      = r_ex_rs1;
    assign bus.ex_rs2      = r_ex_rs2;
    assign bus.ex_imm      = r_ex_imm;
    assign bus.ex_rd       = r_ex_rd;
    assign bus.ex_wb_en    = r_ex_wb_en;
    assign bus.wb_valid    = w_ex_en && bus.ex_ready && r_ex_wb_en;

endmodule

`default_nettype wire

// File: tb/tb_decode.sv
// +----------------------------------------------------------------------+
// | tb_decode : directed self-checking bench for the decode stage        |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_decode;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    decode_if #(.M_WIDTH(32), .OP_WIDTH(7)) bus ();

    decode #(.M_WIDTH(32), .OP_WIDTH(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Static register file contents: xN reads 0x1000+N, x0 reads 0.
    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : (32'h1000 + {27'd0, a});
    endfunction

    assign bus.rf_rs1_data = rf_val(bus.rf_rs1_addr);
    assign bus.rf_rs2_data = rf_val(bus.rf_rs2_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_instr(input string name, input logic [31:0] ins, input logic [31:0] pc,
                               input int delay, input logic [6:0] e_op, input logic [4:0] e_rd,
                               input logic [31:0] e_imm, input logic e_wb);
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        e_rs1 = rf_val(ins[19:15]);
        e_rs2 = rf_val(ins[24:20]);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        bus.pc_in       = pc;
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL %s instr_ready got=%b exp=1", name, bus.instr_ready); end
        tick();
        bus.instr_valid = 1'b0;
        checks++; if (bus.ex_en !== 1'b0) begin errors++; $display("FAIL %s ex_en_at_N got=%b exp=0", name, bus.ex_en); end
        tick();
        checks++; if (bus.ex_en !== 1'b1) begin errors++; $display("FAIL %s ex_en_at_N+1 got=%b exp=1", name, bus.ex_en); end
        checks++; if (bus.ex_op !== e_op) begin errors++; $display("FAIL %s ex_op got=%h exp=%h", name, bus.ex_op, e_op); end
        checks++; if (bus.ex_rd !== e_rd) begin errors++; $display("FAIL %s ex_rd got=%0d exp=%0d", name, bus.ex_rd, e_rd); end
        checks++; if (bus.ex_funct3 !== ins[14:12]) begin errors++; $display("FAIL %s ex_funct3 got=%b exp=%b", name, bus.ex_funct3, ins[14:12]); end
        checks++; if (bus.ex_funct7 !== ins[31:25]) begin errors++; $display("FAIL %s ex_funct7 got=%b exp=%b", name, bus.ex_funct7, ins[31:25]); end
        checks++; if (bus.ex_imm !== e_imm) begin errors++; $display("FAIL %s ex_imm got=%h exp=%h", name, bus.ex_imm, e_imm); end
        checks++; if (bus.ex_wb_en !== e_wb) begin errors++; $display("FAIL %s ex_wb_en got=%b exp=%b", name, bus.ex_wb_en, e_wb); end
        checks++; if (bus.ex_pc !== pc) begin errors++; $display("FAIL %s ex_pc got=%h exp=%h", name, bus.ex_pc, pc); end
        checks++; if (bus.ex_rs1 !== e_rs1 || bus.ex_rs2 !== e_rs2) begin errors++; $display("FAIL %s ex_rs got=%h/%h exp=%h/%h", name, bus.ex_rs1, bus.ex_rs2, e_rs1, e_rs2); end
        tick();
        for (int i = 0; i < delay; i++) begin
            checks++; if (bus.ex_en !== 1'b1 || bus.ex_imm !== e_imm) begin errors++; $display("FAIL %s hold_%0d ex_en=%b imm=%h exp 1/%h", name, i, bus.ex_en, bus.ex_imm, e_imm); end
            tick();
        end
        checks++; if (bus.ex_en !== 1'b1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL %s pre_ready ex_en=%b wb_valid=%b exp 1/0", name, bus.ex_en, bus.wb_valid); end
        bus.ex_ready = 1'b1;
        #1;
        checks++; if (bus.wb_valid !== e_wb) begin errors++; $display("FAIL %s wb_valid got=%b exp=%b", name, bus.wb_valid, e_wb); end
        tick();
        bus.ex_ready = 1'b0;
        checks++; if (bus.ex_en !== 1'b0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL %s recover ex_en=%b wb_valid=%b exp 0/0", name, bus.ex_en, bus.wb_valid); end
        tick();
        checks++; if (bus.ex_en !== 1'b0) begin errors++; $display("FAIL %s idle ex_en got=%b exp=0", name, bus.ex_en); end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (bus.ex_en !== 1'b0 || bus.wb_valid !== 1'b0 || bus.illegal_instr !== 1'b0) begin errors++; $display("FAIL reset_ctrl ex_en=%b wb=%b ill=%b exp 0/0/0", bus.ex_en, bus.wb_valid, bus.illegal_instr); end
        checks++; if (bus.ex_imm !== 32'd0 || bus.ex_pc !== 32'd0 || bus.ex_op !== 7'd0 || bus.ex_rd !== 5'd0) begin errors++; $display("FAIL reset_fields imm=%h pc=%h op=%h rd=%0d exp all 0", bus.ex_imm, bus.ex_pc, bus.ex_op, bus.ex_rd); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_instr_ready got=%b exp=1", bus.instr_ready); end
        checks++; if (bus.ex_wb_en !== 1'b0 || bus.rf_rs1_addr !== 5'd0) begin errors++; $display("FAIL reset_misc wb_en=%b rs1a=%0d exp 0/0", bus.ex_wb_en, bus.rf_rs1_addr); end
    endtask

    task automatic test_formats();
        logic [31:0] ins [8];
        logic [6:0]  op  [8];
        logic [4:0]  rd  [8];
        logic [31:0] imm [8];
        logic        wb  [8];
        ins[0] = 32'h00500093; op[0] = 7'h13; rd[0] = 5'd1; imm[0] = 32'h00000005; wb[0] = 1'b1;
        ins[1] = 32'h123450B7; op[1] = 7'h37; rd[1] = 5'd1; imm[1] = 32'h12345000; wb[1] = 1'b1;
        ins[2] = 32'hFFFFF117; op[2] = 7'h17; rd[2] = 5'd2; imm[2] = 32'hFFFFF000; wb[2] = 1'b1;
        ins[3] = 32'h010000EF; op[3] = 7'h6F; rd[3] = 5'd1; imm[3] = 32'h00000010; wb[3] = 1'b1;
        ins[4] = 32'h00008067; op[4] = 7'h67; rd[4] = 5'd0; imm[4] = 32'h00000000; wb[4] = 1'b0;
        ins[5] = 32'h002081B3; op[5] = 7'h33; rd[5] = 5'd3; imm[5] = 32'h00000000; wb[5] = 1'b1;
        ins[6] = 32'hFFF02283; op[6] = 7'h03; rd[6] = 5'd5; imm[6] = 32'hFFFFFFFF; wb[6] = 1'b1;
        ins[7] = 32'h00000463; op[7] = 7'h63; rd[7] = 5'd8; imm[7] = 32'h00000008; wb[7] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            issue_instr($sformatf("fmt%0d", k), ins[k], 32'h100 + 32'(4 * k), (k == 6) ? 2 : 0,
                        op[k], rd[k], imm[k], wb[k]);
        end
    endtask

    task automatic test_store();
        issue_instr("store", 32'hFE20AE23, 32'h400, 4, 7'h23, 5'd28, 32'hFFFFFFFC, 1'b0);
        checks++; if (bus.ex_funct3 !== 3'b010 || bus.ex_funct7 !== 7'h7F) begin errors++; $display("FAIL store_funct f3=%b f7=%h exp 010/7f", bus.ex_funct3, bus.ex_funct7); end
    endtask

    task automatic test_branch_flush();
        // Buffered ADDI behind a taken branch is discarded.
        bus.instr_valid = 1'b1; bus.instr = 32'h00000463; bus.pc_in = 32'h200;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        checks++; if (bus.ex_en !== 1'b1 || bus.ex_op !== 7'h63) begin errors++; $display("FAIL flush_issue ex_en=%b op=%h exp 1/63", bus.ex_en, bus.ex_op); end
        bus.instr_valid = 1'b1; bus.instr = 32'h00500093; bus.pc_in = 32'h204;
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL flush_buf_accept got=%b exp=1", bus.instr_ready); end
        tick();
        bus.instr_valid = 1'b0;
        bus.ex_ready = 1'b1; bus.ex_flush = 1'b1;
        #1;
        checks++; if (bus.instr_ready !== 1'b0 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle instr_ready=%b wb=%b exp 0/0", bus.instr_ready, bus.wb_valid); end
        tick();
        bus.ex_ready = 1'b0; bus.ex_flush = 1'b0;
        checks++; if (bus.ex_en !== 1'b0 || bus.instr_ready !== 1'b1) begin errors++; $display("FAIL flush_cleared ex_en=%b instr_ready=%b exp 0/1", bus.ex_en, bus.instr_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.ex_en !== 1'b0) begin errors++; $display("FAIL flush_no_issue_%0d ex_en=%b exp=0", i, bus.ex_en); end
        end
        // Offer arriving in the flush cycle with an empty buffer is refused.
        bus.instr_valid = 1'b1; bus.instr = 32'h00000463; bus.pc_in = 32'h300;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        bus.instr_valid = 1'b1; bus.instr = 32'h00500093; bus.pc_in = 32'h304;
        bus.ex_ready = 1'b1; bus.ex_flush = 1'b1;
        #1;
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL flush_refuse instr_ready=%b exp=0", bus.instr_ready); end
        tick();
        bus.instr_valid = 1'b0; bus.ex_ready = 1'b0; bus.ex_flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.ex_en !== 1'b0) begin errors++; $display("FAIL flush_refuse_no_issue_%0d ex_en=%b exp=0", i, bus.ex_en); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog [4];
        int idx, issues, wbs, last_rise;
        logic prev_en;
        prog[0] = 32'h00500093; prog[1] = 32'h00600113;
        prog[2] = 32'h00700193; prog[3] = 32'h00800213;
        idx = 0; issues = 0; wbs = 0; last_rise = 0; prev_en = 1'b0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (bus.ex_en && !prev_en) begin
                if (issues > 0) begin
                    checks++; if (cyc - last_rise != 3) begin errors++; $display("FAIL b2b_spacing_%0d got=%0d exp=3", issues, cyc - last_rise); end
                end
                checks++; if (bus.ex_imm !== 32'(5 + issues) || bus.ex_rd !== 5'(issues + 1)) begin errors++; $display("FAIL b2b_fields_%0d imm=%h rd=%0d exp %h/%0d", issues, bus.ex_imm, bus.ex_rd, 32'(5 + issues), issues + 1); end
                last_rise = cyc;
                issues++;
            end
            bus.ex_ready    = bus.ex_en && prev_en;
            prev_en         = bus.ex_en;
            bus.instr_valid = (idx < 4);
            bus.instr       = (idx < 4) ? prog[idx] : 32'd0;
            bus.pc_in       = 32'h500 + 32'(4 * idx);
            #1;
            if (bus.instr_valid && bus.instr_ready) idx++;
            if (bus.wb_valid) wbs++;
            tick();
        end
        bus.instr_valid = 1'b0; bus.ex_ready = 1'b0;
        checks++; if (issues != 4) begin errors++; $display("FAIL b2b_issue_count got=%0d exp=4", issues); end
        checks++; if (wbs != 4) begin errors++; $display("FAIL b2b_wb_count got=%0d exp=4", wbs); end
        tick();
    endtask

    task automatic test_reset_mid_issue();
        bus.instr_valid = 1'b1; bus.instr = 32'h00500093; bus.pc_in = 32'h600;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        checks++; if (bus.ex_en !== 1'b1) begin errors++; $display("FAIL rst_mid_pre ex_en=%b exp=1", bus.ex_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.ex_en !== 1'b0 || bus.ex_imm !== 32'd0 || bus.ex_rd !== 5'd0 || bus.ex_wb_en !== 1'b0 || bus.ex_pc !== 32'd0) begin errors++; $display("FAIL rst_mid_async ex_en=%b imm=%h rd=%0d wb_en=%b pc=%h exp all 0", bus.ex_en, bus.ex_imm, bus.ex_rd, bus.ex_wb_en, bus.ex_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (bus.instr_ready !== 1'b1 || bus.ex_en !== 1'b0) begin errors++; $display("FAIL rst_mid_release instr_ready=%b ex_en=%b exp 1/0", bus.instr_ready, bus.ex_en); end
    endtask

    task automatic test_illegal();
`ifdef DECODE_ILLEGAL_TRAP_EN
        bus.instr_valid = 1'b1; bus.instr = 32'hFFFFFFFF; bus.pc_in = 32'h700;
        tick();
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.ex_en !== 1'b0 || bus.instr_ready !== 1'b0 || bus.illegal_instr !== 1'b1) begin errors++; $display("FAIL illegal_trap_%0d ex_en=%b instr_ready=%b ill=%b exp 0/0/1", i, bus.ex_en, bus.instr_ready, bus.illegal_instr); end
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.illegal_instr !== 1'b0) begin errors++; $display("FAIL illegal_reset ill=%b exp=0", bus.illegal_instr); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
`else
        issue_instr("illegal_pass", 32'hFFFFFFFF, 32'h700, 0, 7'h7F, 5'd31, 32'd0, 1'b0);
        checks++; if (bus.illegal_instr !== 1'b0) begin errors++; $display("FAIL illegal_flag ill=%b exp=0", bus.illegal_instr); end
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.pc_in       = 32'd0;
        bus.ex_ready    = 1'b0;
        bus.ex_flush    = 1'b0;
        test_reset();
        test_formats();
        test_store();
        test_branch_flush();
        test_back_to_back();
        test_reset_mid_issue();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
